// File: rtl/node_ctrl_sched_pkg.sv
// Shared types for the EER-RL node controller: packet types, TX FSM states, decode pulses.
package node_ctrl_pkg;

  typedef enum logic [2:0] {
    HB          = 3'd0,
    CH_ANNOUNCE = 3'd1,
    INVITE      = 3'd2,
    DATA        = 3'd3,
    ACK         = 3'd4,
    SLOT_ASSIGN = 3'd5
  } pkt_type_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SLOT = 3'd1,
    CCA       = 3'd2,
    BACKOFF   = 3'd3,
    SEND      = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic kch;
    logic mni;
    logic qtu_fmb;
    logic nbr;
    logic reward;
    logic dest;
  } dec_out_t;

  // Truncated to WORD_WIDTH at the point of use.
  localparam logic [63:0] BROADCAST_ID = '1;

endpackage

// File: rtl/node_ctrl_sched_if.sv
// Packet-filter / radio / table-block signal bundle for node_ctrl_sched.
interface node_ctrl_sched_if #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NUM_SLOTS  = 8
);
  localparam int unsigned IW = $clog2(NUM_SLOTS);

  logic                  pkt_valid;
  logic [2:0]            fPacketType;
  logic [WORD_WIDTH-1:0] fHopsFromCH;
  logic [WORD_WIDTH-1:0] fChosenCH;
  logic [WORD_WIDTH-1:0] fTimeslot;
  logic [WORD_WIDTH-1:0] destinationID;
  logic                  channel_clear;
  logic [WORD_WIDTH-1:0] myTimeslot;
  logic [WORD_WIDTH-1:0] myNodeID;
  logic                  role;
  logic                  iHaveData;
  logic [WORD_WIDTH-1:0] chosenCH;
  logic                  tx_done;

  logic                  en_KCH;
  logic                  en_MNI;
  logic                  en_QTU_FMB;
  logic                  en_neighborTable;
  logic                  en_reward;
  logic                  iAmDestination;
  logic                  okToSend;
  logic                  tx_fail;
  logic [IW-1:0]         slot_index;
  logic [2:0]            fsm_state;

  modport master (
    output pkt_valid, fPacketType, fHopsFromCH, fChosenCH, fTimeslot, destinationID,
           channel_clear, myTimeslot, myNodeID, role, iHaveData, chosenCH, tx_done,
    input  en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward, iAmDestination,
           okToSend, tx_fail, slot_index, fsm_state
  );

  modport slave (
    input  pkt_valid, fPacketType, fHopsFromCH, fChosenCH, fTimeslot, destinationID,
           channel_clear, myTimeslot, myNodeID, role, iHaveData, chosenCH, tx_done,
    output en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward, iAmDestination,
           okToSend, tx_fail, slot_index, fsm_state
  );

endinterface

// File: rtl/node_ctrl_sched_slot_timer.sv
// Free-running TDMA frame timer: cycle-within-slot counter and slot index.
module slot_timer #(
  parameter int unsigned NUM_SLOTS   = 8,
  parameter int unsigned SLOT_CYCLES = 64,
  localparam int unsigned IW = $clog2(NUM_SLOTS),
  localparam int unsigned CW = $clog2(SLOT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] slot_cnt,
  output logic [IW-1:0] slot_index,
  output logic          slot_start,
  output logic          slot_end
);
  logic [CW-1:0] slot_cnt_d, slot_cnt_q;
  logic [IW-1:0] slot_index_d, slot_index_q;

  always_comb begin
    slot_start   = (slot_cnt_q == '0);
    slot_end     = (slot_cnt_q == CW'(SLOT_CYCLES - 1));
    slot_cnt_d   = slot_cnt_q + 1'b1;
    slot_index_d = slot_index_q;
    if (slot_end) begin
      slot_cnt_d   = '0;
      slot_index_d = (slot_index_q == IW'(NUM_SLOTS - 1)) ? '0 : slot_index_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q   <= '0;
      slot_index_q <= '0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      slot_index_q <= slot_index_d;
    end
  end

  assign slot_cnt   = slot_cnt_q;
  assign slot_index = slot_index_q;

endmodule

// File: rtl/node_ctrl_sched.sv
// EER-RL node controller: packet decode into table-update pulses, plus TDMA slot-gated TX FSM.
module node_ctrl_sched
  import node_ctrl_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned NUM_SLOTS      = 8,
  parameter int unsigned SLOT_CYCLES    = 64,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned BACKOFF_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  node_ctrl_sched_if.slave  bus
);
  localparam int unsigned IW = $clog2(NUM_SLOTS);
  localparam int unsigned CW = $clog2(SLOT_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned BW = $clog2(BACKOFF_CYCLES + 1);
  localparam logic [WORD_WIDTH-1:0] BCAST = BROADCAST_ID[WORD_WIDTH-1:0];

  logic [CW-1:0] slot_cnt;
  logic [IW-1:0] slot_index;
  logic          slot_start, slot_end;

  slot_timer #(
    .NUM_SLOTS   (NUM_SLOTS),
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .slot_cnt   (slot_cnt),
    .slot_index (slot_index),
    .slot_start (slot_start),
    .slot_end   (slot_end)
  );

  dec_out_t dec_d, dec_q;
  logic     to_me, addressed;

  always_comb begin
    dec_d     = '0;
    to_me     = (bus.destinationID == bus.myNodeID);
    addressed = to_me || (bus.destinationID == BCAST);
    if (bus.pkt_valid) begin
      case (pkt_type_e'(bus.fPacketType))
        HB:          begin dec_d.nbr = 1'b1; dec_d.qtu_fmb = 1'b1; end
        CH_ANNOUNCE: begin dec_d.kch = 1'b1; dec_d.nbr = 1'b1; end
        INVITE:      dec_d.mni = addressed;
        DATA:        begin dec_d.nbr = 1'b1; dec_d.dest = to_me; end
        ACK:         dec_d.reward = to_me;
        SLOT_ASSIGN: dec_d.mni = (bus.fChosenCH == bus.chosenCH);
        default:     dec_d = '0;
      endcase
    end
  end

  tx_state_e     state_d, state_q;
  logic [RW-1:0] retry_d, retry_q, retry_inc;
  logic [BW-1:0] bo_cnt_d, bo_cnt_q;
  logic          tx_fail_d, tx_fail_q;
  logic          own_valid, own_next;
  logic [IW-1:0] own_slot, next_index;

  // CCA is entered on the wrap into the own slot so the CCA cycle is slot_cnt == 0.
  always_comb begin
    own_valid  = bus.role || (bus.myTimeslot < WORD_WIDTH'(NUM_SLOTS));
    own_slot   = bus.role ? '0 : bus.myTimeslot[IW-1:0];
    next_index = (slot_index == IW'(NUM_SLOTS - 1)) ? '0 : slot_index + 1'b1;
    own_next   = own_valid && slot_end && (next_index == own_slot);
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    bo_cnt_d  = '0;
    tx_fail_d = 1'b0;
    retry_inc = (retry_q == RW'(MAX_RETRY)) ? retry_q : retry_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.iHaveData && own_valid) begin
          state_d = WAIT_SLOT;
          retry_d = '0;
        end
      end
      WAIT_SLOT: begin
        if (!bus.iHaveData)  state_d = IDLE;
        else if (own_next)   state_d = CCA;
      end
      CCA: begin
        if (bus.channel_clear) begin
          state_d = SEND;
        end else begin
          retry_d = retry_inc;
          if (retry_inc == RW'(MAX_RETRY)) begin
            tx_fail_d = 1'b1;
            state_d   = IDLE;
          end else if (slot_end) begin
            state_d = WAIT_SLOT;
          end else begin
            state_d = BACKOFF;
          end
        end
      end
      BACKOFF: begin
        if (slot_end)                                   state_d = WAIT_SLOT;
        else if (bo_cnt_q == BW'(BACKOFF_CYCLES - 1))   state_d = CCA;
        else                                            bo_cnt_d = bo_cnt_q + 1'b1;
      end
      SEND: begin
        if (bus.tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q     <= '0;
      state_q   <= IDLE;
      retry_q   <= '0;
      bo_cnt_q  <= '0;
      tx_fail_q <= 1'b0;
    end else begin
      dec_q     <= dec_d;
      state_q   <= state_d;
      retry_q   <= retry_d;
      bo_cnt_q  <= bo_cnt_d;
      tx_fail_q <= tx_fail_d;
    end
  end

  a_start_is_cnt_zero: assert property (@(posedge clk) disable iff (rst)
    slot_start == (slot_cnt == '0));
  a_cca_on_own_slot: assert property (@(posedge clk) disable iff (rst)
    (state_q == WAIT_SLOT && state_d == CCA) |=> (slot_start && slot_index == own_slot));

  assign bus.en_KCH           = dec_q.kch;
  assign bus.en_MNI           = dec_q.mni;
  assign bus.en_QTU_FMB       = dec_q.qtu_fmb;
  assign bus.en_neighborTable = dec_q.nbr;
  assign bus.en_reward        = dec_q.reward;
  assign bus.iAmDestination   = dec_q.dest;
  assign bus.okToSend         = (state_q == SEND);
  assign bus.tx_fail          = tx_fail_q;
  assign bus.slot_index       = slot_index;
  assign bus.fsm_state        = state_q;

endmodule
